// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a variable-latency imem.
// One request per PC, response strobe arrives at least one cycle later.
interface fetch_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_rdata,
        input  inst_data_ok
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_rdata,
        output inst_data_ok
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: owns the PC, runs one fetch at a time against a
// variable-latency imem, buffers a response that lands while F is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stallF,
    input  logic          stallD,
    input  logic          pcsrcD,
    input  logic [31:0]   pcbranchD,
    input  logic          jumpD,
    input  logic [31:0]   pcjumpD,
    fetch_stage_if.master imem,
    output logic [31:0]   pcF,
    output logic [31:0]   instrD,
    output logic [31:0]   pcplus4D,
    output logic          validD,
    output logic          imem_stall
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ibuf;
    logic [31:0] r_instrD;
    logic [31:0] r_pcplus4D;
    logic        r_validD;

    logic [31:0] w_fetched;
    logic [31:0] w_pcplus4F;
    logic [31:0] w_pcnext;
    logic        w_imem_stall;
    logic        w_advance;
    logic        w_redirect;

    always_comb begin
        w_fetched    = r_ibuf;
        w_imem_stall = 1'b1;
        if (r_state == S_WAIT) begin
            w_fetched    = imem.inst_rdata;
            w_imem_stall = ~imem.inst_data_ok;
        end else if (r_state == S_HELD) begin
            w_imem_stall = 1'b0;
        end
    end

    // Jump wins over branch; carry out of PC+4 is dropped so the PC wraps.
    assign w_pcplus4F = r_pc + 32'd4;
    assign w_redirect = pcsrcD | jumpD;
    assign w_pcnext   = jumpD  ? pcjumpD   :
                        pcsrcD ? pcbranchD : w_pcplus4F;
    assign w_advance  = ~w_imem_stall & ~stallF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_ibuf     <= '0;
            r_instrD   <= NOP_INSTR;
            r_pcplus4D <= '0;
            r_validD   <= 1'b0;
        end else begin
            case (r_state)
                S_REQ:  r_state <= S_WAIT;
                S_WAIT: begin
                    if (imem.inst_data_ok) begin
                        if (stallF) begin
                            r_ibuf  <= imem.inst_rdata;
                            r_state <= S_HELD;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HELD: if (!stallF) r_state <= S_REQ;
                default: r_state <= S_REQ;
            endcase

            if (w_advance) r_pc <= w_pcnext;

            // Redirect squashes the wrong-path word; no advance pushes a bubble.
            if (!stallD) begin
                if (w_advance) begin
                    r_pcplus4D <= w_pcplus4F;
                    if (w_redirect) begin
                        r_instrD <= NOP_INSTR;
                        r_validD <= 1'b0;
                    end else begin
                        r_instrD <= w_fetched;
                        r_validD <= 1'b1;
                    end
                end else begin
                    r_instrD <= NOP_INSTR;
                    r_validD <= 1'b0;
                end
            end
        end
    end

    assign imem.inst_req  = (r_state == S_REQ) && !rst;
    assign imem.inst_addr = r_pc;
    assign pcF            = r_pc;
    assign instrD         = r_instrD;
    assign pcplus4D       = r_pcplus4D;
    assign validD         = r_validD;
    assign imem_stall     = w_imem_stall;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table of fetch transactions against a bench-side imem,
// plus hand sequences for held responses, held redirects and mid-fetch reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0;
    logic        stallD = 1'b0;
    logic        pcsrcD = 1'b0;
    logic        jumpD = 1'b0;
    logic [31:0] pcbranchD = '0;
    logic [31:0] pcjumpD = '0;
    logic [31:0] pcF, instrD, pcplus4D;
    logic        validD, imem_stall;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage_if imem();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .stallF     (stallF),
        .stallD     (stallD),
        .pcsrcD     (pcsrcD),
        .pcbranchD  (pcbranchD),
        .jumpD      (jumpD),
        .pcjumpD    (pcjumpD),
        .imem       (imem),
        .pcF        (pcF),
        .instrD     (instrD),
        .pcplus4D   (pcplus4D),
        .validD     (validD),
        .imem_stall (imem_stall)
    );

    typedef struct {
        int          lat;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic [31:0] addr;
        logic [31:0] pcn;
        logic        v;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        v;
        logic [31:0] pc4;
        logic [31:0] pcn;
    } exp_t;

    vec_t vecs[11];
    exp_t sbq[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return {lo, ~lo};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic idle();
        imem.inst_data_ok = 1'b0;
        pcsrcD = 1'b0;
        jumpD  = 1'b0;
        stallF = 1'b0;
        stallD = 1'b0;
    endtask

    // Compares the IF/ID result of the previous advance edge.
    task automatic sb_check();
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("instrD", instrD, e.instr);
            chk1("validD", validD, e.v);
            chk("pcplus4D", pcplus4D, e.pc4);
            chk("pcF_next", pcF, e.pcn);
        end
    endtask

    // Called so that the next negedge falls in an S_REQ cycle.
    task automatic do_fetch(input vec_t v);
        exp_t e;
        @(negedge clk);
        idle();
        #1;
        sb_check();
        chk1("req_issue", imem.inst_req, 1'b1);
        chk("req_addr", imem.inst_addr, v.addr);
        chk("pcF", pcF, v.addr);
        chk1("stall_req", imem_stall, 1'b1);
        for (int j = 1; j < v.lat; j++) begin
            @(negedge clk);
            #1;
            chk1("stall_wait", imem_stall, 1'b1);
            chk1("no_rereq", imem.inst_req, 1'b0);
            chk1("bubble_wait", validD, 1'b0);
        end
        @(negedge clk);
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata   = memword(v.addr);
        pcsrcD    = v.br;
        pcbranchD = v.bt;
        jumpD     = v.jp;
        pcjumpD   = v.jt;
        #1;
        chk1("stall_ok", imem_stall, 1'b0);
        e.instr = v.v ? memword(v.addr) : NOP;
        e.v     = v.v;
        e.pc4   = v.addr + 32'd4;
        e.pcn   = v.pcn;
        sbq.push_back(e);
    endtask

    initial begin
        vec_t hv;
        imem.inst_data_ok = 1'b0;
        imem.inst_rdata   = '0;

        //            lat br bt            jp jt            addr          pcn           v
        vecs[0]  = '{1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h4,        1};
        vecs[1]  = '{1, 0, 32'h0,        0, 32'h0,        32'h4,        32'h8,        1};
        vecs[2]  = '{1, 0, 32'h0,        0, 32'h0,        32'h8,        32'hC,        1};
        vecs[3]  = '{1, 0, 32'h0,        0, 32'h0,        32'hC,        32'h10,       1};
        vecs[4]  = '{3, 0, 32'h0,        0, 32'h0,        32'h10,       32'h14,       1};
        vecs[5]  = '{2, 0, 32'h0,        1, 32'h20,       32'h14,       32'h20,       0};
        vecs[6]  = '{1, 1, 32'h100,      0, 32'h0,        32'h20,       32'h100,      0};
        vecs[7]  = '{1, 1, 32'h300,      1, 32'h200,      32'h100,      32'h200,      0};
        vecs[8]  = '{1, 0, 32'h0,        0, 32'h0,        32'h200,      32'h204,      1};
        vecs[9]  = '{1, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h204,     32'hFFFF_FFFC, 0};
        vecs[10] = '{1, 0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 32'h0,       1};

        // Reset state, with inst_req forced low while rst is high.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pcF", pcF, 32'h0);
        chk("rst_instrD", instrD, NOP);
        chk("rst_pcplus4D", pcplus4D, 32'h0);
        chk1("rst_validD", validD, 1'b0);
        chk1("rst_req", imem.inst_req, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) do_fetch(vecs[i]);

        // Response lands under stallF/stallD and is held four cycles.
        @(negedge clk);
        idle();
        #1;
        sb_check();
        chk1("held_req", imem.inst_req, 1'b1);
        chk("held_addr", imem.inst_addr, 32'h0);
        @(negedge clk);
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata   = memword(32'h0);
        stallF = 1'b1;
        stallD = 1'b1;
        #1;
        chk1("held_ok", imem_stall, 1'b0);
        chk("held_instr0", instrD, NOP);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            imem.inst_data_ok = 1'b0;
            #1;
            chk1("held_noreq", imem.inst_req, 1'b0);
            chk1("held_stall", imem_stall, 1'b0);
            chk("held_instrD", instrD, NOP);
            chk("held_pcF", pcF, 32'h0);
        end
        @(negedge clk);
        stallF = 1'b0;
        stallD = 1'b0;
        @(negedge clk);
        idle();
        #1;
        chk("rel_instrD", instrD, memword(32'h0));
        chk1("rel_validD", validD, 1'b1);
        chk("rel_pcplus4D", pcplus4D, 32'h4);
        chk("rel_pcF", pcF, 32'h4);
        chk1("rel_req", imem.inst_req, 1'b1);

        // Branch held across stall cycles is applied once, at the advance edge.
        pcsrcD    = 1'b1;
        pcbranchD = 32'h80;
        stallF    = 1'b1;
        @(negedge clk);
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata   = memword(32'h4);
        #1;
        chk1("hbr_ok", imem_stall, 1'b0);
        @(negedge clk);
        imem.inst_data_ok = 1'b0;
        #1;
        chk1("hbr_noreq", imem.inst_req, 1'b0);
        chk("hbr_pcF_hold", pcF, 32'h4);
        chk1("hbr_bubble", validD, 1'b0);
        @(negedge clk);
        stallF = 1'b0;
        #1;
        hv = '{1, 0, 32'h0, 0, 32'h0, 32'h80, 32'h84, 1};
        @(negedge clk);
        idle();
        #1;
        chk("hbr_pcF", pcF, 32'h80);
        chk("hbr_instrD", instrD, NOP);
        chk1("hbr_validD", validD, 1'b0);
        chk("hbr_pcplus4D", pcplus4D, 32'h8);
        chk("hbr_addr", imem.inst_addr, 32'h80);

        // Re-enter the normal flow: this edge starts S_REQ->S_WAIT, so step back one.
        @(negedge clk);
        imem.inst_data_ok = 1'b1;
        imem.inst_rdata   = memword(32'h80);
        #1;
        sbq.push_back('{memword(32'h80), 1'b1, 32'h84, 32'h84});
        do_fetch('{2, 0, 32'h0, 1, 32'h40, 32'h84, 32'h40, 0});

        // Reset while waiting on the fetch of 0x40.
        @(negedge clk);
        idle();
        #1;
        sb_check();
        chk("mr_addr", imem.inst_addr, 32'h40);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mr_pcF", pcF, 32'h0);
        chk1("mr_validD", validD, 1'b0);
        chk("mr_instrD", instrD, NOP);
        chk("mr_pcplus4D", pcplus4D, 32'h0);
        chk1("mr_req_low", imem.inst_req, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_fetch('{1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h4, 1});
        @(negedge clk);
        idle();
        #1;
        sb_check();
        chk1("sb_empty", sbq.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Owns the PC and issues fetches to a variable-latency instruction memory.
- Applies branch/jump redirects resolved in D and obeys stallF/stallD from the hazard unit.
- Exports imem_stall so the datapath can hold F while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, bubble instruction written into D

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
stallF  in  1  hazard stall for F (hold PC)
stallD  in  1  hazard stall for D (hold IF/ID)
pcsrcD  in  1  branch in D taken
pcbranchD  in  32  branch target
jumpD  in  1  jump in D
pcjumpD  in  32  jump target
inst_req  out  1  one-cycle fetch request
inst_addr  out  32  fetch address (= pcF)
inst_rdata  in  32  returned instruction, valid with inst_data_ok
inst_data_ok  in  1  response strobe, at least 1 cycle after inst_req
pcF  out  32  current fetch PC
instrD  out  32  IF/ID instruction
pcplus4D  out  32  IF/ID PC+4
validD  out  1  instrD is a real instruction, not a bubble
imem_stall  out  1  fetch not ready this cycle

Behaviour:
- Reset (rst=1 at edge):
  - pcF=RESET_PC; state=S_REQ.
  - instrD=NOP_INSTR, pcplus4D=0, validD=0, ibuf cleared.
  - inst_req forced 0 while rst=1.
  - The instruction memory shares rst and drops any outstanding response.
  - Reset mid-fetch (S_WAIT/S_HELD) gives the same result.
- FSM states:
  - S_REQ: inst_req=1, inst_addr=pcF; next S_WAIT.
  - S_WAIT: waiting for the response.
    - inst_data_ok & ~stallF: advance; next S_REQ.
    - inst_data_ok & stallF: capture inst_rdata into ibuf; next S_HELD.
    - otherwise stay.
  - S_HELD: instruction buffered; stallF=0 advances; next S_REQ.
- fetched = inst_rdata in S_WAIT, ibuf in S_HELD.
- imem_stall = ~((S_WAIT & inst_data_ok) | S_HELD). Always 1 in S_REQ; minimum fetch cost is 2 cycles.
- advance = ~imem_stall & ~stallF.
- pcnext priority: jumpD ? pcjumpD : pcsrcD ? pcbranchD : pcF+4 (32-bit wrap, carry discarded).
- On advance:
  - pcF<=pcnext.
  - If stallD=0: pcplus4D<=pcF+4.
    - Redirect (pcsrcD|jumpD): instrD<=NOP_INSTR, validD<=0 (squash wrong-path fetch).
    - Else: instrD<=fetched, validD<=1.
- No advance:
  - pcF holds.
  - If stallD=0: instrD<=NOP_INSTR, validD<=0, pcplus4D holds (bubble into D).
- stallD=1 always holds instrD/pcplus4D/validD, whether or not F advances.
- Redirect is sampled only at the advance edge; a redirect held across stall cycles is applied exactly once.
- Exactly one inst_req per PC value; a response arriving while stalled is never lost or re-requested.
- No request is issued outside S_REQ, so at most one fetch is outstanding.

Test Plan:
- Reset then free-running memory with 1-cycle latency, no stalls -> inst_req every 2nd cycle; pcF 0,4,8,C; instrD matches memory words; validD=1 on each advance edge, 0 (bubble) between.
- Memory latency 3 cycles at pcF=0x10 -> imem_stall=1 for 3 cycles; one inst_req; instrD loaded once, bubbles meanwhile.
- stallF=stallD=1 asserted in the inst_data_ok cycle and held 4 cycles -> state S_HELD; no new inst_req; instrD unchanged; on release, buffered word enters D and pcF advances by 4.
- pcsrcD=1, pcbranchD=0x100 at the advance edge with pcF=0x20 -> pcF=0x100, instrD=NOP, validD=0; next fetch address 0x100. With jumpD=1, pcjumpD=0x200 as well, pcF=0x200.
- rst pulsed in S_WAIT with pcF=0x40 -> next cycle pcF=RESET_PC, validD=0, inst_req=1 after rst drops.
- pcF=0xFFFF_FFFC, no redirect -> pcF wraps to 0x0; pcplus4D=0x0.
